// File: rtl/spi_board_router_pkg.sv
// Shared types and sizing helpers for the SPI board router and its per-board slots.
`timescale 1ns/1ps
package spi_board_router_pkg;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        SETTLING = 2'd1,
        READY    = 2'd2,
        ACTIVE   = 2'd3
    } slot_state_t;

    // Bits needed to hold the values 0..count-1, never less than one bit.
    function automatic int width_for(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/spi_board_router_slot.sv
// One readout-board slot: live-pin synchroniser and debouncer, hot-plug FSM,
// registered pad enable and sticky fault flag.
`timescale 1ns/1ps
module spi_board_router_slot
    import spi_board_router_pkg::*;
#(
    parameter int DEB_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic live_raw,
    input  logic host_en,
    input  logic fault_clr,
    input  logic cs_idle,
    output logic active,
    output logic oe,
    output logic fault
);

    localparam int DW = width_for(DEB_CYCLES);
    localparam int SW = width_for(SETTLE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          deb_live;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] settle_cnt;
    slot_state_t   state;
    slot_state_t   next_state;
    logic          fault_set;

    // Any sample equal to the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            deb_live <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1 <= live_raw;
            sync2 <= sync1;
            if (sync2 == deb_live) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_live <= sync2;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ABSENT;
            settle_cnt <= '0;
            oe         <= 1'b0;
        end else begin
            state <= next_state;
            oe    <= (state == ACTIVE);
            if (state != SETTLING) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Enable changes only take effect between frames so a transfer is never cut.
    always_comb begin
        next_state = state;
        case (state)
            ABSENT:   if (deb_live) next_state = SETTLING;
            SETTLING: if (!deb_live) next_state = ABSENT;
                      else if (settle_cnt == SETTLE_LAST) next_state = READY;
            READY:    if (!deb_live) next_state = ABSENT;
                      else if (host_en && cs_idle) next_state = ACTIVE;
            ACTIVE:   if (!deb_live) next_state = ABSENT;
                      else if (!host_en && cs_idle) next_state = READY;
            default:  next_state = ABSENT;
        endcase
    end

    always_comb begin
        active    = (state == ACTIVE);
        fault_set = !cs_idle && ((state != ACTIVE) || !deb_live);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (fault_set) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_board_router.sv
// Fans the single SPI master out to hot-pluggable readout boards, steering MISO back
// from the one selected board and flagging overlapping chip selects.
`timescale 1ns/1ps
module spi_board_router
    import spi_board_router_pkg::*;
#(
    parameter int N_BOARDS      = 4,
    parameter int CS_PER_BOARD  = 3,
    parameter int DEB_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_BOARDS-1:0]              host_en,
    input  logic [N_BOARDS-1:0]              fault_clr,
    input  logic                             spi_mosi,
    input  logic                             spi_sclk,
    input  logic [N_BOARDS*CS_PER_BOARD-1:0] spi_csn,
    output logic                             spi_miso,
    input  logic [N_BOARDS-1:0]              live_in,
    input  logic [N_BOARDS-1:0]              brd_miso,
    output logic [N_BOARDS-1:0]              brd_mosi,
    output logic [N_BOARDS-1:0]              brd_sclk,
    output logic [N_BOARDS*CS_PER_BOARD-1:0] brd_csn,
    output logic [N_BOARDS-1:0]              brd_oe,
    output logic [N_BOARDS-1:0]              brd_active,
    output logic [N_BOARDS-1:0]              fault,
    output logic                             multi_sel_err
);

    localparam int NCS = N_BOARDS * CS_PER_BOARD;
    localparam int OW  = width_for(N_BOARDS);

    logic [N_BOARDS-1:0] cs_idle;
    logic                any_low;
    logic                multi_low;
    logic [OW-1:0]       owner;

    for (genvar b = 0; b < N_BOARDS; b++) begin : g_slot
        assign cs_idle[b] = &spi_csn[b*CS_PER_BOARD +: CS_PER_BOARD];

        spi_board_router_slot #(
            .DEB_CYCLES   (DEB_CYCLES),
            .SETTLE_CYCLES(SETTLE_CYCLES)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .live_raw (live_in[b]),
            .host_en  (host_en[b]),
            .fault_clr(fault_clr[b]),
            .cs_idle  (cs_idle[b]),
            .active   (brd_active[b]),
            .oe       (brd_oe[b]),
            .fault    (fault[b])
        );

        assign brd_csn[b*CS_PER_BOARD +: CS_PER_BOARD] =
            brd_oe[b] ? spi_csn[b*CS_PER_BOARD +: CS_PER_BOARD] : {CS_PER_BOARD{1'b1}};
        assign brd_mosi[b] = brd_oe[b] & spi_mosi;
        assign brd_sclk[b] = brd_oe[b] & spi_sclk;
    end

    // Scan all chip selects: note whether any, or more than one, is low and who owns it.
    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        owner     = '0;
        for (int i = 0; i < NCS; i++) begin
            if (!spi_csn[i]) begin
                multi_low = multi_low | any_low;
                any_low   = 1'b1;
                owner     = OW'(i / CS_PER_BOARD);
            end
        end
    end

    assign spi_miso = (any_low && !multi_low && brd_active[owner]) ? brd_miso[owner] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            multi_sel_err <= 1'b0;
        end else if (multi_low) begin
            multi_sel_err <= 1'b1;
        end else if (|fault_clr) begin
            multi_sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_board_router.sv
// Directed scoreboard bench for spi_board_router: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_spi_board_router;

    localparam int N   = 4;
    localparam int CS  = 3;
    localparam int DEB = 16;
    localparam int SET = 8;

    typedef enum {K_ACTIVE, K_OE, K_FAULT, K_CSN, K_MISO, K_MSE, K_MOSI, K_SCLK} kind_t;
    typedef struct {
        string name;
        kind_t kind;
        int    idx;
        int    exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    host_en;
    logic [N-1:0]    fault_clr;
    logic            spi_mosi;
    logic            spi_sclk;
    logic [N*CS-1:0] spi_csn;
    logic            spi_miso;
    logic [N-1:0]    live_in;
    logic [N-1:0]    brd_miso;
    logic [N-1:0]    brd_mosi;
    logic [N-1:0]    brd_sclk;
    logic [N*CS-1:0] brd_csn;
    logic [N-1:0]    brd_oe;
    logic [N-1:0]    brd_active;
    logic [N-1:0]    fault;
    logic            multi_sel_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    spi_board_router #(
        .N_BOARDS     (N),
        .CS_PER_BOARD (CS),
        .DEB_CYCLES   (DEB),
        .SETTLE_CYCLES(SET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_en      (host_en),
        .fault_clr    (fault_clr),
        .spi_mosi     (spi_mosi),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_miso     (spi_miso),
        .live_in      (live_in),
        .brd_miso     (brd_miso),
        .brd_mosi     (brd_mosi),
        .brd_sclk     (brd_sclk),
        .brd_csn      (brd_csn),
        .brd_oe       (brd_oe),
        .brd_active   (brd_active),
        .fault        (fault),
        .multi_sel_err(multi_sel_err)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int readOut(input kind_t k, input int i);
        case (k)
            K_ACTIVE: return int'(brd_active[i]);
            K_OE:     return int'(brd_oe[i]);
            K_FAULT:  return int'(fault[i]);
            K_CSN:    return int'(brd_csn[i*CS +: CS]);
            K_MISO:   return int'(spi_miso);
            K_MSE:    return int'(multi_sel_err);
            K_MOSI:   return int'(brd_mosi[i]);
            K_SCLK:   return int'(brd_sclk[i]);
            default:  return -1;
        endcase
    endfunction

    // Monitor: every negedge, compare all outputs the stimulus has queued expectations for.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compare(e.name, readOut(e.kind, e.idx), e.exp);
        end
    end

    task automatic checkOutput(input string name, input kind_t k, input int i, input int exp);
        exp_t e;
        e.name = name;
        e.kind = k;
        e.idx  = i;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N*CS-1:0] csn, input logic [N-1:0] hen,
                                 input logic [N-1:0] live, input logic [N-1:0] bmiso);
        spi_csn  = csn;
        host_en  = hen;
        live_in  = live;
        brd_miso = bmiso;
    endtask

    task automatic waitActive(input int b, input logic lvl, input int budget, output int n);
        n = 0;
        while (brd_active[b] !== lvl && n < budget) begin
            cycle();
            n++;
        end
    endtask

    task automatic checkWindow(input string name, input int n, input int lo, input int hi);
        compare(name, int'(n >= lo && n <= hi), 1);
        if (n < lo || n > hi) $display("[TB] %s took %0d cycles, window %0d..%0d", name, n, lo, hi);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        fault_clr = '0;
        spi_mosi  = 1'b0;
        spi_sclk  = 1'b0;
        applyStimulus('1, 4'b1101, 4'b1101, 4'b0000);
        repeat (3) cycle();

        for (int b = 0; b < N; b++) begin
            checkOutput("rst_active", K_ACTIVE, b, 0);
            checkOutput("rst_oe",     K_OE,     b, 0);
            checkOutput("rst_csn",    K_CSN,    b, 7);
            checkOutput("rst_fault",  K_FAULT,  b, 0);
            checkOutput("rst_mosi",   K_MOSI,   b, 0);
        end
        checkOutput("rst_miso", K_MISO, 0, 0);
        checkOutput("rst_mse",  K_MSE,  0, 0);
        cycle();

        // Hot-plug bring-up of boards 0, 2 and 3.
        rst = 1'b0;
        waitActive(0, 1'b1, 4 + DEB + SET + 10, n);
        checkWindow("t1_latency", n, 2 + DEB + SET, 4 + DEB + SET);
        checkOutput("t1_oe_lag", K_OE, 0, 0);
        cycle();
        checkOutput("t1_oe",       K_OE,     0, 1);
        checkOutput("t1_active2",  K_ACTIVE, 2, 1);
        checkOutput("t1_active3",  K_ACTIVE, 3, 1);
        checkOutput("t1_active1",  K_ACTIVE, 1, 0);
        applyStimulus(~12'h001, 4'b1101, 4'b1101, 4'b0001);
        spi_mosi = 1'b1;
        spi_sclk = 1'b1;
        checkOutput("t1_csn0",  K_CSN,  0, 6);
        checkOutput("t1_csn1",  K_CSN,  1, 7);
        checkOutput("t1_miso1", K_MISO, 0, 1);
        checkOutput("t1_mosi0", K_MOSI, 0, 1);
        checkOutput("t1_sclk0", K_SCLK, 0, 1);
        checkOutput("t1_mosi1", K_MOSI, 1, 0);
        cycle();
        brd_miso = 4'b1110;
        checkOutput("t1_miso0", K_MISO,  0, 0);
        checkOutput("t1_fault", K_FAULT, 0, 0);
        cycle();
        applyStimulus('1, 4'b1101, 4'b1101, 4'b0000);
        spi_mosi = 1'b0;
        spi_sclk = 1'b0;
        cycle();

        // Board 1 live pin bounces faster than the debounce window.
        for (int c = 0; c < 5000; c++) begin
            if (c % 7 == 0) live_in[1] = ~live_in[1];
            cycle();
            if (c % 250 == 249) begin
                checkOutput("t2_active", K_ACTIVE, 1, 0);
                checkOutput("t2_oe",     K_OE,     1, 0);
                checkOutput("t2_csn",    K_CSN,    1, 7);
            end
        end
        live_in[1] = 1'b0;
        cycle();

        // Board 2 disabled mid-frame: it finishes the frame before leaving ACTIVE.
        spi_csn = ~12'h040;
        checkOutput("t3_csn", K_CSN, 2, 6);
        cycle();
        host_en[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checkOutput("t3_hold", K_ACTIVE, 2, 1);
        end
        spi_csn = '1;
        cycle();
        checkOutput("t3_ready",  K_ACTIVE, 2, 0);
        checkOutput("t3_oe_lag", K_OE,     2, 1);
        cycle();
        checkOutput("t3_oe",    K_OE,    2, 0);
        checkOutput("t3_fault", K_FAULT, 2, 0);

        // Board 3 unplugged mid-frame.
        spi_csn = ~12'h200;
        checkOutput("t4_csn", K_CSN, 3, 6);
        cycle();
        live_in[3] = 1'b0;
        waitActive(3, 1'b0, DEB + 14, n);
        checkWindow("t4_latency", n, DEB + 2, DEB + 4);
        checkOutput("t4_fault", K_FAULT, 3, 1);
        cycle();
        checkOutput("t4_csn_off", K_CSN, 3, 7);
        checkOutput("t4_oe",      K_OE,  3, 0);
        fault_clr[3] = 1'b1;
        cycle();
        fault_clr[3] = 1'b0;
        checkOutput("t4_set_wins", K_FAULT, 3, 1);
        spi_csn = '1;
        cycle();
        fault_clr[3] = 1'b1;
        cycle();
        fault_clr[3] = 1'b0;
        checkOutput("t4_clr", K_FAULT, 3, 0);

        // Board 1 plugged in but not enabled: selecting it is a fault.
        live_in[1] = 1'b1;
        repeat (DEB + SET + 8) cycle();
        checkOutput("t6_active", K_ACTIVE, 1, 0);
        checkOutput("t6_fault0", K_FAULT,  1, 0);
        applyStimulus(~12'h010, host_en, live_in, 4'b1111);
        checkOutput("t6_csn",  K_CSN,  1, 7);
        checkOutput("t6_miso", K_MISO, 0, 0);
        cycle();
        checkOutput("t6_fault", K_FAULT, 1, 1);
        checkOutput("t6_mse",   K_MSE,   0, 0);
        spi_csn = '1;
        cycle();

        // Two boards selected together.
        spi_csn = ~12'h009;
        checkOutput("t5_miso",    K_MISO, 0, 0);
        checkOutput("t5_mse_lag", K_MSE,  0, 0);
        cycle();
        checkOutput("t5_mse", K_MSE, 0, 1);
        spi_csn = '1;
        cycle();
        checkOutput("t5_sticky", K_MSE, 0, 1);
        spi_csn = ~12'h001;
        checkOutput("t5_single_miso", K_MISO, 0, 1);
        cycle();
        spi_csn = '1;
        fault_clr = 4'b0010;
        cycle();
        fault_clr = '0;
        checkOutput("t5_mse_clr",   K_MSE,   0, 0);
        checkOutput("t5_fault_clr", K_FAULT, 1, 0);

        // Reset mid-frame drops every board at once.
        spi_csn = ~12'h001;
        checkOutput("rf_csn_pre", K_CSN, 0, 6);
        cycle();
        rst = 1'b1;
        cycle();
        checkOutput("rf_active", K_ACTIVE, 0, 0);
        checkOutput("rf_oe",     K_OE,     0, 0);
        checkOutput("rf_csn",    K_CSN,    0, 7);
        rst = 1'b0;
        spi_csn = '1;
        repeat (4) cycle();
        checkOutput("rf_redeb", K_ACTIVE, 0, 0);
        cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
